// File: rtl/tick_timer_pkg.sv
// tick_timer_pkg: shared types and divider constants for the tick timer scheduler
package tick_timer_pkg;
  typedef enum logic [1:0] {CH_IDLE, CH_RUN, CH_HOLD} ch_state_t;
  localparam int CLK_DIV_HW = 50_000_000;
  localparam int CLK_DIV_SIM = 4;
endpackage

// File: rtl/tick_timer_sched_timer_channel.sv
// timer_channel: one countdown channel driven by the shared tick, with hold, retrigger and cancel
module timer_channel import tick_timer_pkg::*; #(
  parameter int CNT_W = 8
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic             start,
  input  logic             cancel,
  input  logic             hold,
  input  logic             tick,
  input  logic [CNT_W-1:0] duration,
  output logic             busy,
  output logic             done
);
  ch_state_t state;
  logic [CNT_W-1:0] remaining;
  assign busy = state != CH_IDLE;
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state <= CH_IDLE;
      remaining <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state <= CH_IDLE;
        remaining <= '0;
      end else if (start) begin
        remaining <= duration;
        state <= duration == '0 ? CH_IDLE : CH_RUN;
        done <= duration == '0;
      end else if (state == CH_RUN && hold) begin
        state <= CH_HOLD;
      end else if (state == CH_HOLD && !hold) begin
        state <= CH_RUN;
      end else if (state == CH_RUN && tick) begin
        remaining <= remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) begin
          state <= CH_IDLE;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/tick_timer_sched.sv
// tick_timer_sched: one prescaler shared by NUM_CH countdown channels through a single-cycle tick
module tick_timer_sched import tick_timer_pkg::*; #(
  parameter int CLK_DIV = CLK_DIV_HW,
  parameter int NUM_CH = 2,
  parameter int CNT_W = 8
) (
  input  logic                    clk_100MHz,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       cancel,
  input  logic [NUM_CH-1:0]       hold,
  input  logic [NUM_CH*CNT_W-1:0] duration,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic                    tick
);
  logic [31:0] presc;
  logic presc_max;
  logic any_busy;
  assign any_busy = |busy;
  assign presc_max = presc == 32'(CLK_DIV - 1);
  assign tick = any_busy && presc_max;
  // Idle parks the prescaler at zero, so the first start always gets a full first tick period
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) presc <= '0;
    else presc <= (!any_busy || presc_max) ? '0 : presc + 32'd1;
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk_100MHz(clk_100MHz),
      .reset_n(reset_n),
      .start(start[i]),
      .cancel(cancel[i]),
      .hold(hold[i]),
      .tick(tick),
      .duration(duration[i*CNT_W +: CNT_W]),
      .busy(busy[i]),
      .done(done[i])
    );
  end
endmodule

// File: tb/tb_tick_timer_sched.sv
// tb_tick_timer_sched: directed timing scenarios plus randomized run against a behavioural model
module tb_tick_timer_sched;
  localparam int CLK_DIV = 4;
  localparam int NUM_CH = 2;
  localparam int CNT_W = 8;
  logic clk_100MHz = 1'b0;
  logic reset_n = 1'b0;
  logic [NUM_CH-1:0] start, cancel, hold, busy, done;
  logic [NUM_CH*CNT_W-1:0] duration;
  logic tick;
  int checks = 0;
  int errors = 0;
  always #5 clk_100MHz = ~clk_100MHz;
  tick_timer_sched #(.CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_100MHz(clk_100MHz),
    .reset_n(reset_n),
    .start(start),
    .cancel(cancel),
    .hold(hold),
    .duration(duration),
    .busy(busy),
    .done(done),
    .tick(tick)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic chk_out(string tag, logic [1:0] b, logic [1:0] d, logic t);
    check({tag, " busy"}, 32'(busy), 32'(b));
    check({tag, " done"}, 32'(done), 32'(d));
    check({tag, " tick"}, 32'(tick), 32'(t));
  endtask
  task automatic idle_in;
    start = '0;
    cancel = '0;
    hold = '0;
    duration = '0;
  endtask
  task automatic step;
    @(posedge clk_100MHz);
    #1;
  endtask
  task automatic gap;
    idle_in;
    repeat (3) step;
  endtask
  int m_st[NUM_CH];
  int m_rem[NUM_CH];
  bit m_done[NUM_CH];
  int phase;
  initial begin
    idle_in;
    start[0] = 1'b1;
    duration[7:0] = 8'd3;
    repeat (3) step;
    chk_out("reset", 2'b00, 2'b00, 1'b0);
    idle_in;
    step;
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step;
      chk_out($sformatf("post_reset c%0d", c), 2'b00, 2'b00, 1'b0);
    end
    for (int c = 0; c <= 16; c++) begin
      chk_out($sformatf("d3 c%0d", c), {1'b0, c >= 1 && c <= 12}, {1'b0, c == 13}, c == 4 || c == 8 || c == 12);
      idle_in;
      if (c == 0) begin
        start[0] = 1'b1;
        duration[7:0] = 8'd3;
      end
      step;
    end
    gap;
    for (int c = 0; c <= 8; c++) begin
      chk_out($sformatf("d0 c%0d", c), 2'b00, {1'b0, c == 1}, 1'b0);
      idle_in;
      if (c == 0) start[0] = 1'b1;
      step;
    end
    gap;
    for (int c = 0; c <= 16; c++) begin
      chk_out($sformatf("two c%0d", c), {c >= 7 && c <= 8, c >= 1 && c <= 12}, {c == 9, c == 13}, c == 4 || c == 8 || c == 12);
      idle_in;
      if (c == 0) begin
        start[0] = 1'b1;
        duration[7:0] = 8'd3;
      end
      if (c == 6) begin
        start[1] = 1'b1;
        duration[15:8] = 8'd1;
      end
      step;
    end
    gap;
    for (int c = 0; c <= 20; c++) begin
      chk_out($sformatf("hold c%0d", c), {1'b0, c >= 1 && c <= 16}, {1'b0, c == 17}, c != 0 && c <= 16 && c % 4 == 0);
      idle_in;
      if (c == 0) begin
        start[0] = 1'b1;
        duration[7:0] = 8'd2;
      end
      hold[0] = c >= 2 && c <= 9;
      step;
    end
    gap;
    for (int c = 0; c <= 10; c++) begin
      chk_out($sformatf("cancel c%0d", c), {1'b0, c >= 1 && c <= 5}, 2'b00, c == 4);
      if (c == 7) check("cancel presc", dut.presc, 32'd0);
      idle_in;
      if (c == 0 || c == 5) begin
        start[0] = 1'b1;
        duration[7:0] = 8'd5;
      end
      if (c == 5) cancel[0] = 1'b1;
      step;
    end
    gap;
    for (int c = 0; c <= 24; c++) begin
      if (c == 6) begin
        chk_out("areset before", 2'b01, 2'b00, 1'b0);
        reset_n = 1'b0;
        #1;
        chk_out("areset now", 2'b00, 2'b00, 1'b0);
      end else begin
        chk_out($sformatf("areset c%0d", c), {1'b0, c >= 1 && c < 6}, 2'b00, c == 4);
      end
      idle_in;
      if (c == 0) begin
        start[0] = 1'b1;
        duration[7:0] = 8'd5;
      end
      if (c == 8) reset_n = 1'b1;
      step;
    end
    gap;
    for (int i = 0; i < NUM_CH; i++) begin
      m_st[i] = 0;
      m_rem[i] = 0;
      m_done[i] = 0;
    end
    phase = 0;
    for (int n = 0; n < 2000; n++) begin
      logic [1:0] eb, ed;
      logic et;
      bit any;
      any = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        eb[i] = m_st[i] != 0;
        ed[i] = m_done[i];
        any |= m_st[i] != 0;
      end
      et = any && phase == CLK_DIV - 1;
      chk_out($sformatf("rand n%0d", n), eb, ed, et);
      for (int i = 0; i < NUM_CH; i++) begin
        int d;
        d = int'($urandom_range(0, 6));
        if (m_st[i] != 0 && d == 0) d = 1;
        start[i] = $urandom_range(0, 11) == 0;
        cancel[i] = $urandom_range(0, 39) == 0;
        if ($urandom_range(0, 9) == 0) hold[i] = ~hold[i];
        duration[i*CNT_W +: CNT_W] = CNT_W'(d);
        m_done[i] = 0;
        if (cancel[i]) m_st[i] = 0;
        else if (start[i]) begin
          if (d == 0) begin
            m_st[i] = 0;
            m_done[i] = 1;
          end else begin
            m_st[i] = 1;
            m_rem[i] = d;
          end
        end else if (m_st[i] == 1 && hold[i]) m_st[i] = 2;
        else if (m_st[i] == 2 && !hold[i]) m_st[i] = 1;
        else if (m_st[i] == 1 && et) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            m_st[i] = 0;
            m_done[i] = 1;
          end
        end
      end
      phase = any ? (phase + 1) % CLK_DIV : 0;
      step;
    end
    idle_in;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tick_timer_sched.md
Name: tick_timer_sched

Overview:
Shared-timebase timer scheduler for the elevator controller. It owns one prescaler that divides clk_100MHz down to a single-cycle tick strobe. It multiplexes that tick among NUM_CH independent countdown channels: door-open hold, floor-travel time and similar delays. Each requester gets a start/cancel/hold interface and a done pulse, so no consumer needs its own divider or derived clock.

Parameters:
CLK_DIV, 50_000_000, clk_100MHz cycles per tick (0.5 s); benches use 4
NUM_CH, 2, number of timer channels
CNT_W, 8, width of per-channel duration in ticks

Ports:
clk_100MHz  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  NUM_CH  per-channel load-and-run pulse
cancel  in  NUM_CH  per-channel abort
hold  in  NUM_CH  per-channel level; freezes countdown while high
duration  in  NUM_CH*CNT_W  per-channel tick count, channel i at [i*CNT_W +: CNT_W]; sampled on start
busy  out  NUM_CH  channel in RUN or HOLD
done  out  NUM_CH  one-cycle pulse on normal expiry
tick  out  1  timebase strobe, high one cycle per period

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All channels go to IDLE; remaining=0; prescaler presc=0.
  - busy=0, done=0, tick=0.
  - Reset mid-count discards all state and produces no done pulse.
- Prescaler:
  - presc is a 32-bit register counting 0..CLK_DIV-1 and wrapping to 0.
  - tick = (presc==CLK_DIV-1) and at least one channel in RUN/HOLD. tick decodes only registered state.
  - While every channel is IDLE, presc is held at 0.
  - A start that arrives while no channel is busy forces presc to 0, so the first tick occurs exactly CLK_DIV cycles after busy rises.
  - A start while another channel is busy does not disturb presc. First-tick quantisation error is then up to one tick (accepted).
- Channel FSM (per channel, states IDLE, RUN, HOLD):
  - IDLE, start=1, duration>0: remaining<=duration, go to RUN. busy rises the next cycle.
  - IDLE, start=1, duration=0: stay IDLE; done=1 the next cycle; busy never rises.
  - RUN, tick=1: remaining decrements. If remaining==1, go to IDLE and pulse done next cycle; busy falls in the same cycle done rises.
  - RUN, hold=1: go to HOLD. HOLD ignores tick. HOLD with hold=0 returns to RUN. Ticks that fall while in HOLD are lost, not deferred.
  - RUN/HOLD, start=1: reload remaining from duration and go to RUN (retrigger); no done pulse.
  - Any state, cancel=1: go to IDLE with no done pulse.
- Priority per channel: cancel > start > hold > tick.
- Latency: done rises D*CLK_DIV+1 cycles after the start cycle, when presc restarts and there is no hold.
- Channels are fully independent. Simultaneous expiry of several channels gives simultaneous done pulses.
- When the last busy channel leaves RUN/HOLD, presc returns to 0 on the following cycle.
- done is registered and never high for two consecutive cycles unless a new start with duration=0 is applied.

Decomposition:
- Package tick_timer_pkg holds:
  - typedef enum logic [1:0] {CH_IDLE, CH_RUN, CH_HOLD} ch_state_t
  - localparam CLK_DIV_HW = 50_000_000
  - localparam CLK_DIV_SIM = 4
- One sub-module, timer_channel (FSM, remaining counter, done register). It is instantiated NUM_CH times in a generate loop.
- The prescaler and tick decode stay in tick_timer_sched.

Test Plan:
All scenarios use CLK_DIV=4, NUM_CH=2, CNT_W=8; start pulses are applied in cycle 0.
- Reset: reset_n=0 with start[0]=1 active -> busy=00, done=00, tick=0. After release, all outputs stay 0 until the first start.
- ch0 start, duration=3 -> busy[0]=1 in cycles 1-12; tick in cycles 4, 8, 12; done[0]=1 only in cycle 13; busy[0]=0 from cycle 13.
- ch0 start, duration=0 -> done[0]=1 in cycle 1 only; busy[0] stays 0; tick never asserts.
- ch0 start D=3 in cycle 0, then ch1 start D=1 in cycle 6 -> prescaler is not reset; done[1] in cycle 9; done[0] in cycle 13.
- ch0 start D=2, hold[0]=1 in cycles 2-9 -> ticks in cycles 4 and 8 are ignored; remaining decrements at ticks 12 and 16; done[0] in cycle 17.
- ch0 start D=5, then start[0]=1 and cancel[0]=1 together in cycle 5 -> busy[0]=0 from cycle 6; no done pulse; presc=0 by cycle 7.
- Separate run: ch0 start D=5, reset_n=0 in cycle 6 -> outputs clear immediately (asynchronously); no done pulse.
